// File: rtl/iob_fifo_async_asym.sv
// Dual-clock FIFO with independent power-of-2 related write/read widths.
// Storage and pointers are kept in MIN_W units; pointers cross domains as Gray code.
`timescale 1ns/1ps
module iob_fifo_async_asym #(
   parameter int W_DATA_W   = 8,
   parameter int R_DATA_W   = 32,
   parameter int ADDR_W     = 4,
   parameter int AFULL_LVL  = 3,
   parameter int AEMPTY_LVL = 1
) (
   input  logic                rst,
   input  logic                w_clk,
   input  logic                r_clk,
   input  logic                w_en,
   input  logic [W_DATA_W-1:0] w_data,
   output logic                w_full,
   output logic                w_afull,
   output logic [ADDR_W:0]     w_level,
   input  logic                r_en,
   output logic [R_DATA_W-1:0] r_data,
   output logic                r_empty,
   output logic                r_aempty,
   output logic [ADDR_W:0]     r_level
);

   localparam int MIN_W  = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
   localparam int WR     = W_DATA_W / MIN_W;
   localparam int RR     = R_DATA_W / MIN_W;
   localparam int WR_LOG = $clog2(WR);
   localparam int RR_LOG = $clog2(RR);
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PW     = ADDR_W + 1;
   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0] WR_P     = PW'(WR);
   localparam logic [PW-1:0] RR_P     = PW'(RR);
   localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_LVL);
   localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_LVL);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [MIN_W-1:0] mem [DEPTH];

   logic [1:0] w_rst_sync, r_rst_sync;
   logic       w_rst_n, r_rst_n;

   // Reset asserts asynchronously, releases on the second local clock edge.
   always_ff @(posedge w_clk or negedge rst)
      if (!rst) w_rst_sync <= '0;
      else      w_rst_sync <= {w_rst_sync[0], 1'b1};

   always_ff @(posedge r_clk or negedge rst)
      if (!rst) r_rst_sync <= '0;
      else      r_rst_sync <= {r_rst_sync[0], 1'b1};

   assign w_rst_n = w_rst_sync[1];
   assign r_rst_n = r_rst_sync[1];

   logic [PW-1:0] wptr, wptr_nxt, wgray, rgray_p1, rgray_p2, rptr_w, occ_w_nxt;
   logic [PW-1:0] rptr, rptr_nxt, rgray, wgray_p1, wgray_p2, wptr_r, occ_r_nxt;
   logic          w_ok, r_ok;
   logic [R_DATA_W-1:0] rd_word;

   // Write domain. Gray code is taken on the word-granular pointer so that
   // exactly one bit toggles per write even when WR > 1.
   assign w_ok      = w_en && !w_full;
   assign wptr_nxt  = wptr + (w_ok ? WR_P : '0);
   assign rptr_w    = gray2bin(rgray_p2) << RR_LOG;
   assign occ_w_nxt = wptr_nxt - rptr_w;

   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         wptr     <= '0;
         wgray    <= '0;
         rgray_p1 <= '0;
         rgray_p2 <= '0;
         w_full   <= 1'b0;
         w_afull  <= 1'b0;
         w_level  <= '0;
      end else begin
         wptr     <= wptr_nxt;
         wgray    <= bin2gray(wptr_nxt >> WR_LOG);
         rgray_p1 <= rgray;
         rgray_p2 <= rgray_p1;
         w_full   <= (DEPTH_P - occ_w_nxt) < WR_P;
         w_level  <= occ_w_nxt >> WR_LOG;
         w_afull  <= (occ_w_nxt >> WR_LOG) >= AFULL_P;
      end

   always_ff @(posedge w_clk)
      if (w_ok)
         for (int i = 0; i < WR; i++)
            mem[wptr[ADDR_W-1:0] + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];

   // Read domain
   assign r_ok      = r_en && !r_empty;
   assign rptr_nxt  = rptr + (r_ok ? RR_P : '0);
   assign wptr_r    = gray2bin(wgray_p2) << WR_LOG;
   assign occ_r_nxt = wptr_r - rptr_nxt;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < RR; i++)
         rd_word[i*MIN_W +: MIN_W] = mem[rptr[ADDR_W-1:0] + ADDR_W'(i)];
   end

   always_ff @(posedge r_clk or negedge r_rst_n)
      if (!r_rst_n) begin
         rptr     <= '0;
         rgray    <= '0;
         wgray_p1 <= '0;
         wgray_p2 <= '0;
         r_data   <= '0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_level  <= '0;
      end else begin
         rptr     <= rptr_nxt;
         rgray    <= bin2gray(rptr_nxt >> RR_LOG);
         wgray_p1 <= wgray;
         wgray_p2 <= wgray_p1;
         if (r_ok) r_data <= rd_word;
         r_empty  <= occ_r_nxt < RR_P;
         r_level  <= occ_r_nxt >> RR_LOG;
         r_aempty <= (occ_r_nxt >> RR_LOG) <= AEMPTY_P;
      end

endmodule

// File: tb/tb_iob_fifo_async_asym.sv
// Directed bench for iob_fifo_async_asym: narrow-to-wide default instance plus
// a wide-to-narrow instance, with per-scenario tasks and inline checks.
`timescale 1ns/1ps
module tb_iob_fifo_async_asym;

   logic        rst;
   logic        w_clk, r_clk;
   logic        w_en;
   logic [7:0]  w_data;
   logic        w_full, w_afull;
   logic [4:0]  w_level;
   logic        r_en;
   logic [31:0] r_data;
   logic        r_empty, r_aempty;
   logic [4:0]  r_level;

   logic        w_en2;
   logic [31:0] w_data2;
   logic        w_full2, w_afull2;
   logic [4:0]  w_level2;
   logic        r_en2;
   logic [7:0]  r_data2;
   logic        r_empty2, r_aempty2;
   logic [4:0]  r_level2;

   int tests = 0;
   int fails = 0;

   iob_fifo_async_asym dut (
      .rst(rst), .w_clk(w_clk), .r_clk(r_clk),
      .w_en(w_en), .w_data(w_data), .w_full(w_full), .w_afull(w_afull), .w_level(w_level),
      .r_en(r_en), .r_data(r_data), .r_empty(r_empty), .r_aempty(r_aempty), .r_level(r_level)
   );

   iob_fifo_async_asym #(.W_DATA_W(32), .R_DATA_W(8)) dut2 (
      .rst(rst), .w_clk(w_clk), .r_clk(r_clk),
      .w_en(w_en2), .w_data(w_data2), .w_full(w_full2), .w_afull(w_afull2), .w_level(w_level2),
      .r_en(r_en2), .r_data(r_data2), .r_empty(r_empty2), .r_aempty(r_aempty2), .r_level(r_level2)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;
   initial r_clk = 1'b0;
   always #6.5 r_clk = ~r_clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // Callers start at a negedge of w_clk; returns at the negedge after the write edge.
   task automatic write_byte(input logic [7:0] d);
      w_en = 1'b1; w_data = d;
      @(negedge w_clk);
      w_en = 1'b0;
   endtask

   task automatic read_word(output logic [31:0] d);
      r_en = 1'b1;
      @(negedge r_clk);
      r_en = 1'b0;
      d = r_data;
   endtask

   task automatic wait_level(input int lvl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge r_clk);
         if (r_level == 5'(lvl) && !r_empty) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; #1; rst = 1'b0;
      #40;
      tests++;
      if ({r_empty, r_aempty, w_full, w_afull} !== 4'b1100) begin
         fails++; $display("FAIL reset_flags: got e/ae/f/af=%b want 1100", {r_empty, r_aempty, w_full, w_afull});
      end
      tests++;
      if ({w_level, r_level} !== 10'd0) begin
         fails++; $display("FAIL reset_levels: got w=%0d r=%0d want 0 0", w_level, r_level);
      end
      tests++;
      if (r_data !== 32'h0) begin
         fails++; $display("FAIL reset_rdata: got %h want 00000000", r_data);
      end
      tests++;
      if ({r_empty2, r_aempty2, w_full2, w_afull2, r_data2} !== 12'b1100_0000_0000) begin
         fails++; $display("FAIL reset_inst2: got %b want 110000000000", {r_empty2, r_aempty2, w_full2, w_afull2, r_data2});
      end
      rst = 1'b1;
      repeat (5) @(negedge r_clk);
   endtask

   task automatic test_partial_word;
      logic [31:0] d;
      bit ok;
      @(negedge w_clk);
      for (int i = 0; i < 3; i++) write_byte(8'(i));
      repeat (8) @(negedge r_clk);
      tests++;
      if (r_empty !== 1'b1 || r_level !== 5'd0) begin
         fails++; $display("FAIL partial_hidden: got empty=%b level=%0d want 1 0", r_empty, r_level);
      end
      @(negedge w_clk);
      write_byte(8'h03);
      wait_level(1, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL first_word_visible: got empty=%b level=%0d want 0 1", r_empty, r_level);
      end
      tests++;
      if (r_aempty !== 1'b1) begin
         fails++; $display("FAIL aempty_at_1: got %b want 1", r_aempty);
      end
      read_word(d);
      tests++;
      if (d !== 32'h03020100) begin
         fails++; $display("FAIL first_word_data: got %h want 03020100", d);
      end
      tests++;
      if (r_empty !== 1'b1) begin
         fails++; $display("FAIL empty_after_read: got %b want 1", r_empty);
      end
   endtask

   task automatic test_full;
      logic [31:0] d;
      logic [31:0] exp;
      bit ok;
      @(negedge w_clk);
      repeat (6) @(negedge w_clk);
      tests++;
      if (w_level !== 5'd0) begin
         fails++; $display("FAIL wlevel_drained: got %0d want 0", w_level);
      end
      for (int i = 0; i < 16; i++) begin
         write_byte(8'(i));
         if (i == 14) begin
            tests++;
            if (w_full !== 1'b0) begin
               fails++; $display("FAIL not_full_at_15: got %b want 0", w_full);
            end
         end
      end
      tests++;
      if ({w_full, w_afull, w_level} !== {1'b1, 1'b1, 5'd16}) begin
         fails++; $display("FAIL full_at_16: got full=%b afull=%b level=%0d want 1 1 16", w_full, w_afull, w_level);
      end
      write_byte(8'hEE);
      tests++;
      if (w_level !== 5'd16 || w_full !== 1'b1) begin
         fails++; $display("FAIL write_while_full: got level=%0d full=%b want 16 1", w_level, w_full);
      end
      wait_level(4, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL rlevel_4: got level=%0d want 4", r_level);
      end
      tests++;
      if (r_aempty !== 1'b0) begin
         fails++; $display("FAIL aempty_at_4: got %b want 0", r_aempty);
      end
      for (int k = 0; k < 4; k++) begin
         read_word(d);
         exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
         tests++;
         if (d !== exp) begin
            fails++; $display("FAIL full_read_%0d: got %h want %h", k, d, exp);
         end
      end
      tests++;
      if (r_empty !== 1'b1) begin
         fails++; $display("FAIL empty_after_drain: got %b want 1", r_empty);
      end
   endtask

   task automatic test_stream;
      logic [7:0] q[$];
      int got = 0;
      repeat (6) @(negedge w_clk);
      fork
         begin : writer
            int wcyc = 0;
            bit acc;
            @(negedge w_clk);
            for (int i = 0; i < 256; i++) begin
               if (i == 80 || i == 170) repeat (300) @(negedge w_clk);
               repeat ($urandom_range(0, 2)) @(negedge w_clk);
               w_data = 8'(i); w_en = 1'b1;
               acc = 1'b0;
               while (!acc && wcyc < 30000) begin
                  if (!w_full) begin
                     acc = 1'b1;
                     q.push_back(8'(i));
                  end
                  @(negedge w_clk);
                  wcyc++;
               end
               w_en = 1'b0;
            end
            tests++;
            if (wcyc >= 30000) begin
               fails++; $display("FAIL stream_writer_timeout: got %0d cycles want < 30000", wcyc);
            end
         end
         begin : reader
            int rcyc = 0;
            bit pend = 1'b0;
            logic [31:0] exp = '0;
            while (got < 64 && rcyc < 40000) begin
               @(negedge r_clk);
               rcyc++;
               if (pend) begin
                  pend = 1'b0;
                  tests++;
                  if (r_data !== exp) begin
                     fails++; $display("FAIL stream_word_%0d: got %h want %h", got - 1, r_data, exp);
                  end
               end
               r_en = ($urandom_range(0, 3) != 0);
               if (r_en && !r_empty) begin
                  tests++;
                  if (q.size() < 4) begin
                     fails++; $display("FAIL stream_false_nonempty: got %0d bytes queued want >= 4", q.size());
                     exp = 'x;
                  end else begin
                     exp = {q[3], q[2], q[1], q[0]};
                     repeat (4) void'(q.pop_front());
                  end
                  pend = 1'b1;
                  got++;
               end
            end
            @(negedge r_clk);
            r_en = 1'b0;
            if (pend) begin
               tests++;
               if (r_data !== exp) begin
                  fails++; $display("FAIL stream_word_last: got %h want %h", r_data, exp);
               end
            end
         end
      join
      tests++;
      if (got !== 64 || q.size() !== 0) begin
         fails++; $display("FAIL stream_count: got %0d words, %0d left want 64, 0", got, q.size());
      end
   endtask

   task automatic test_midstream_reset;
      logic [31:0] d;
      bit ok;
      @(negedge w_clk);
      for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
      repeat (6) @(negedge w_clk);
      tests++;
      if (w_level !== 5'd5 || w_afull !== 1'b1) begin
         fails++; $display("FAIL pre_reset_level: got level=%0d afull=%b want 5 1", w_level, w_afull);
      end
      #3 rst = 1'b0;
      #1;
      tests++;
      if ({r_empty, r_aempty, w_full, w_afull, w_level, r_level} !== {4'b1100, 10'd0}) begin
         fails++; $display("FAIL midreset_flags: got e/ae/f/af=%b wl=%0d rl=%0d want 1100 0 0",
                           {r_empty, r_aempty, w_full, w_afull}, w_level, r_level);
      end
      tests++;
      if (r_data !== 32'h0) begin
         fails++; $display("FAIL midreset_rdata: got %h want 00000000", r_data);
      end
      #30 rst = 1'b1;
      repeat (5) @(negedge r_clk);
      @(negedge w_clk);
      for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
      wait_level(1, ok);
      read_word(d);
      tests++;
      if (d !== 32'hA3A2A1A0) begin
         fails++; $display("FAIL post_reset_word: got %h want a3a2a1a0", d);
      end
   endtask

   task automatic test_wide_write;
      logic [7:0] exp_b [4];
      bit ok;
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      @(negedge w_clk);
      w_en2 = 1'b1; w_data2 = 32'h44332211;
      @(negedge w_clk);
      w_en2 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge r_clk);
         if (!r_empty2 && r_level2 == 5'd4) ok = 1'b1;
      end
      tests++;
      if (!ok) begin
         fails++; $display("FAIL wide_rlevel: got empty=%b level=%0d want 0 4", r_empty2, r_level2);
      end
      for (int k = 0; k < 4; k++) begin
         r_en2 = 1'b1;
         @(negedge r_clk);
         r_en2 = 1'b0;
         tests++;
         if (r_data2 !== exp_b[k]) begin
            fails++; $display("FAIL wide_byte_%0d: got %h want %h", k, r_data2, exp_b[k]);
         end
      end
      tests++;
      if (r_empty2 !== 1'b1) begin
         fails++; $display("FAIL wide_empty: got %b want 1", r_empty2);
      end
      repeat (6) @(negedge w_clk);
      for (int i = 0; i < 4; i++) begin
         w_en2 = 1'b1; w_data2 = 32'hC0DE0000 + 32'(i);
         @(negedge w_clk);
         w_en2 = 1'b0;
         if (i == 2) begin
            tests++;
            if (w_full2 !== 1'b0) begin
               fails++; $display("FAIL wide_not_full_3: got %b want 0", w_full2);
            end
         end
      end
      tests++;
      if (w_full2 !== 1'b1 || w_level2 !== 5'd4) begin
         fails++; $display("FAIL wide_full_4: got full=%b level=%0d want 1 4", w_full2, w_level2);
      end
   endtask

   initial begin
      rst = 1'b1;
      w_en = 1'b0; w_data = '0; r_en = 1'b0;
      w_en2 = 1'b0; w_data2 = '0; r_en2 = 1'b0;
      test_reset();
      test_partial_word();
      test_full();
      test_stream();
      test_midstream_reset();
      test_wide_write();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
